// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: command-driven initiator for a registered-read
// register file. It accepts LOADI/ADD/SUB/READ commands over a valid/ready
// handshake, then sequences the read latency, the ALU and the write-back.
// Each completed command is reported on a one-cycle res_valid strobe.
// Optional build macro REGFILE_R0_ZERO_EN makes r0 a constant zero:
// source field 0 reads as 0, and writes to r0 are suppressed.
module regfile_access_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] rf_datain,
    output logic [ADDR_W-1:0] rf_addrw,
    output logic [ADDR_W-1:0] rf_addrr1,
    output logic [ADDR_W-1:0] rf_addrr2,
    output logic              rf_w,
    output logic              rf_r,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_LOADI = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    state_t              state_q, state_d;
    op_t                 op_q;
    logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   result_q;
    logic                carry_q;
    logic                res_valid_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_carry_q;

    logic                accept;
    logic [DATA_W-1:0]   src1, src2;
    logic [DATA_W:0]     sum, diff;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;

`ifdef REGFILE_R0_ZERO_EN
    assign src1 = (rs1_q == '0) ? '0 : rf_dout1;
    assign src2 = (rs2_q == '0) ? '0 : rf_dout2;
    assign rf_w = (state_q == ST_WRITE) && (rd_q != '0);
`else
    assign src1 = rf_dout1;
    assign src2 = rf_dout2;
    assign rf_w = (state_q == ST_WRITE);
`endif

    // The extra MSB of the widened add is the carry; of the subtract, the borrow.
    assign sum  = {1'b0, src1} + {1'b0, src2};
    assign diff = {1'b0, src1} - {1'b0, src2};

    // Register-file controls come only from state and latched fields.
    assign rf_r      = (state_q == ST_READ);
    assign rf_addrw  = rd_q;
    assign rf_addrr1 = rs1_q;
    assign rf_addrr2 = rs2_q;
    assign rf_datain = (op_q == OP_LOADI) ? imm_q : result_q;

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;

    // Next-state decode: LOADI skips the read phase; READ op skips write-back.
    always_comb begin
        // NOTE: state_d is given its default first, so no path through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (op_t'(cmd_op) == OP_LOADI) ? ST_WRITE : ST_READ;
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = (op_q == OP_READ) ? ST_IDLE : ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (Rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Command latch, ALU result register and completion reporting.
    always_ff @(posedge clk) begin
        if (Rst) begin
            op_q        <= OP_LOADI;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
                imm_q <= cmd_imm;
            end
            if (state_q == ST_EXEC) begin
                case (op_q)
                    OP_ADD: begin
                        result_q <= sum[DATA_W-1:0];
                        carry_q  <= sum[DATA_W];
                    end
                    OP_SUB: begin
                        result_q <= diff[DATA_W-1:0];
                        carry_q  <= diff[DATA_W];
                    end
                    default: ;
                endcase
                if (op_q == OP_READ) begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= src1;
                    res_carry_q <= 1'b0;
                end
            end
            if (state_q == ST_WRITE) begin
                res_valid_q <= 1'b1;
                res_data_q  <= rf_datain;
                res_carry_q <= (op_q == OP_LOADI) ? 1'b0 : carry_q;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl. A behavioural 16x8 register
// file with registered reads sits downstream. A table of directed commands
// is applied, followed by hand sequences for reset, back-to-back commands
// and reset mid-operation. Build macro REGFILE_R0_ZERO_EN adds the r0 checks.
module tb_regfile_access_ctrl;

    localparam logic [1:0] LOADI = 2'b00, ADD = 2'b01, SUB = 2'b10, RD = 2'b11;

    logic       clk, Rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [7:0] cmd_imm;
    logic [7:0] rf_datain;
    logic [3:0] rf_addrw, rf_addrr1, rf_addrr2;
    logic       rf_w, rf_r;
    logic [7:0] rf_dout1, rf_dout2;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_carry;
    logic       busy;

    int total = 0;
    int bad   = 0;

    regfile_access_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .Rst       (Rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .rf_datain (rf_datain),
        .rf_addrw  (rf_addrw),
        .rf_addrr1 (rf_addrr1),
        .rf_addrr2 (rf_addrr2),
        .rf_w      (rf_w),
        .rf_r      (rf_r),
        .rf_dout1  (rf_dout1),
        .rf_dout2  (rf_dout2),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_carry (res_carry),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural register file: write on rf_w, registered read on rf_r.
    logic [7:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rf_dout1 = 8'h00;
        rf_dout2 = 8'h00;
    end
    always @(posedge clk) begin
        if (rf_w) mem[rf_addrw] <= rf_datain;
        if (rf_r) begin
            rf_dout1 <= mem[rf_addrr1];
            rf_dout2 <= mem[rf_addrr2];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and follow it to its res_valid strobe.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] rd,
                           input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] imm,
                           input logic [7:0] exp_data, input logic exp_carry, input bit exp_write);
        int         lat_exp, cyc, wcnt, rcnt, busy_bad;
        logic [3:0] waddr, raddr1, raddr2;
        logic [7:0] wdata, exp_wdata;
        lat_exp  = (op == LOADI) ? 2 : (op == RD) ? 3 : 4;
        wcnt = 0; rcnt = 0; busy_bad = 0;
        waddr = 4'h0; raddr1 = 4'h0; raddr2 = 4'h0; wdata = 8'h00;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, " ready"}, cmd_ready, 1);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cyc = 1;
        while (cyc <= 12 && !res_valid) begin
            if (cmd_ready || !busy) busy_bad++;
            if (rf_w) begin wcnt++; waddr = rf_addrw; wdata = rf_datain; end
            if (rf_r) begin rcnt++; raddr1 = rf_addrr1; raddr2 = rf_addrr2; end
            step();
            cyc++;
        end
        check({tag, " latency"}, cyc, lat_exp);
        check({tag, " res_valid"}, res_valid, 1);
        check({tag, " res_data"}, res_data, exp_data);
        check({tag, " res_carry"}, res_carry, exp_carry);
        check({tag, " busy"}, busy_bad, 0);
        check({tag, " rf_w count"}, wcnt, exp_write ? 1 : 0);
        if (exp_write) begin
            exp_wdata = (op == LOADI) ? imm : exp_data;
            check({tag, " rf_addrw"}, waddr, rd);
            check({tag, " rf_datain"}, wdata, exp_wdata);
        end
        check({tag, " rf_r count"}, rcnt, (op == LOADI) ? 0 : 1);
        if (op != LOADI) check({tag, " rf_addrr1"}, raddr1, rs1);
        if (op == ADD || op == SUB) check({tag, " rf_addrr2"}, raddr2, rs2);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] rd, rs1, rs2;
        logic [7:0] imm;
        logic [7:0] exp_data;
        logic       exp_carry;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int n;
        vecs[0]  = '{LOADI, 4'd3,  4'd0, 4'd0, 8'h5A, 8'h5A, 1'b0};
        vecs[1]  = '{RD,    4'd0,  4'd3, 4'd0, 8'h00, 8'h5A, 1'b0};
        vecs[2]  = '{LOADI, 4'd1,  4'd0, 4'd0, 8'hF0, 8'hF0, 1'b0};
        vecs[3]  = '{LOADI, 4'd2,  4'd0, 4'd0, 8'h20, 8'h20, 1'b0};
        vecs[4]  = '{ADD,   4'd4,  4'd1, 4'd2, 8'h00, 8'h10, 1'b1};
        vecs[5]  = '{RD,    4'd0,  4'd4, 4'd0, 8'h00, 8'h10, 1'b0};
        vecs[6]  = '{SUB,   4'd5,  4'd2, 4'd1, 8'h00, 8'h30, 1'b1};
        vecs[7]  = '{SUB,   4'd6,  4'd1, 4'd2, 8'h00, 8'hD0, 1'b0};
        vecs[8]  = '{ADD,   4'd9,  4'd3, 4'd3, 8'h00, 8'hB4, 1'b0};
        vecs[9]  = '{SUB,   4'd10, 4'd3, 4'd3, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{RD,    4'd0,  4'd6, 4'd0, 8'h00, 8'hD0, 1'b0};
        vecs[11] = '{LOADI, 4'd1,  4'd0, 4'd0, 8'h03, 8'h03, 1'b0};

        // Reset held two cycles with a command offered: nothing may be accepted.
        Rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = LOADI; cmd_rd = 4'd3; cmd_rs1 = 4'd0; cmd_rs2 = 4'd0; cmd_imm = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst cmd_ready", cmd_ready, 1);
            check("rst busy", busy, 0);
            check("rst rf_w", rf_w, 0);
            check("rst rf_r", rf_r, 0);
            check("rst res_valid", res_valid, 0);
            check("rst res_data", res_data, 8'h00);
            check("rst res_carry", res_carry, 0);
            check("rst rf_addrw", rf_addrw, 4'h0);
            check("rst rf_datain", rf_datain, 8'h00);
        end
        Rst = 1'b0;
        cmd_valid = 1'b0;
        step();
        check("post-rst ready", cmd_ready, 1);
        check("post-rst rf_w", rf_w, 0);
        check("post-rst r3 untouched", mem[3], 8'h00);

        for (int i = 0; i < 12; i++)
            run_cmd($sformatf("v%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                    vecs[i].imm, vecs[i].exp_data, vecs[i].exp_carry, vecs[i].op != RD);

        // Back-to-back ADD r1=r1+r1 with cmd_valid held: 0x03 -> 0x06 -> 0x0C.
        cmd_op = ADD; cmd_rd = 4'd1; cmd_rs1 = 4'd1; cmd_rs2 = 4'd1; cmd_imm = 8'h00;
        cmd_valid = 1'b1;
        check("b2b C0 ready", cmd_ready, 1);
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("b2b C%0d ready", c), cmd_ready, 0);
        end
        step();
        check("b2b C4 res_valid", res_valid, 1);
        check("b2b C4 res_data", res_data, 8'h06);
        check("b2b C4 ready", cmd_ready, 1);
        for (int c = 5; c <= 7; c++) begin
            step();
            check($sformatf("b2b C%0d ready", c), cmd_ready, 0);
            check($sformatf("b2b C%0d res_valid", c), res_valid, 0);
        end
        step();
        check("b2b C8 res_valid", res_valid, 1);
        check("b2b C8 res_data", res_data, 8'h0C);
        check("b2b C8 res_carry", res_carry, 0);
        cmd_valid = 1'b0;
        step();
        check("b2b C9 res_valid", res_valid, 0);
        check("b2b C9 ready", cmd_ready, 1);

        // Reset during EXEC of ADD r7=r1+r2 abandons the command.
        run_cmd("ld r7", LOADI, 4'd7, 4'd0, 4'd0, 8'h77, 8'h77, 1'b0, 1'b1);
        cmd_op = ADD; cmd_rd = 4'd7; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("abort C1 rf_r", rf_r, 1);
        step();
        check("abort C2 rf_w", rf_w, 0);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        check("abort ready", cmd_ready, 1);
        check("abort res_data", res_data, 8'h00);
        check("abort res_carry", res_carry, 0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (rf_w || res_valid) n++;
            step();
        end
        check("abort quiet", n, 0);
        run_cmd("rd r7", RD, 4'd0, 4'd7, 4'd0, 8'h00, 8'h77, 1'b0, 1'b0);

`ifdef REGFILE_R0_ZERO_EN
        run_cmd("ld r0", LOADI, 4'd0, 4'd0, 4'd0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_cmd("add r8", ADD, 4'd8, 4'd0, 4'd2, 8'h00, 8'h20, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Command-driven initiator that sits upstream of the 16x8 register file and drives all of its control ports (write address/data/enable, two read addresses, read-load strobe).
- Accepts one command at a time over a valid/ready handshake: load-immediate, add, subtract or read.
- Sequences the register file's registered-read latency, computes the ALU result and writes it back.
- Reports each completed command on a single-cycle result strobe.

Parameters:
- DATA_W, 8, register and result data width.
- ADDR_W, 4, register address width (2**ADDR_W registers).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  00 LOADI, 01 ADD, 10 SUB, 11 READ.
- cmd_rd  in  ADDR_W  destination register.
- cmd_rs1  in  ADDR_W  source register 1.
- cmd_rs2  in  ADDR_W  source register 2.
- cmd_imm  in  DATA_W  immediate value for LOADI.
- rf_datain  out  DATA_W  write data to register file.
- rf_addrw  out  ADDR_W  write address.
- rf_addrr1  out  ADDR_W  read address 1.
- rf_addrr2  out  ADDR_W  read address 2.
- rf_w  out  1  write enable.
- rf_r  out  1  read-load strobe.
- rf_dout1  in  DATA_W  registered read data 1, valid the cycle after rf_r.
- rf_dout2  in  DATA_W  registered read data 2, valid the cycle after rf_r.
- res_valid  out  1  one-cycle completion strobe.
- res_data  out  DATA_W  result value, held until the next completion.
- res_carry  out  1  carry/borrow flag, held until the next completion.
- busy  out  1  equals the inverse of cmd_ready.

Behaviour:
- States are IDLE, READ, EXEC and WRITE. The handshake fires when cmd_valid and cmd_ready are both high. At that edge the op, rd, rs1, rs2 and imm fields are latched.
- All rf_* outputs decode only from the state register and the latched fields. There is no combinational path from cmd_* to rf_*.
- rf_r is high only in READ. rf_w is high only in WRITE. Outside those states, addresses and data hold their last latched values.
- LOADI: IDLE -> WRITE, with rf_addrw=rd and rf_datain=imm, then -> IDLE. res_data=imm and res_carry=0.
- ADD and SUB: IDLE -> READ (rf_addrr1=rs1, rf_addrr2=rs2) -> EXEC -> WRITE (rf_addrw=rd, rf_datain=result) -> IDLE.
  - In EXEC, rf_dout1/2 are sampled and the result is registered.
- READ op: IDLE -> READ -> EXEC -> IDLE. res_data=rf_dout1 and res_carry=0. No write occurs.
- Arithmetic:
  - ADD forms a (DATA_W+1)-bit sum. res_data is the low DATA_W bits and res_carry is the MSB.
  - SUB: res_data = (rs1 - rs2) mod 2**DATA_W. res_carry=1 exactly when rs1 < rs2 (unsigned borrow).
- Latency, with the accept cycle as C0:
  - LOADI: WRITE in C1, res_valid in C2.
  - ADD/SUB: READ C1, EXEC C2, WRITE C3, res_valid in C4.
  - READ op: res_valid in C3.
- The res_valid cycle is the IDLE cycle in which a new command can be accepted. Back-to-back commands therefore see the previous write, because the write commits at the end of the WRITE cycle.
- rd equal to rs1 or rs2 is legal. Sources are read before the write.
- If cmd_valid is high while not in IDLE, the command is ignored. The producer must hold it until cmd_ready.
- Reset, sampled on the edge:
  - Values after reset: state=IDLE, cmd_ready=1, busy=0, rf_w=0, rf_r=0, res_valid=0, res_data=0, res_carry=0, and all latched fields and rf address/data outputs 0.
  - Reset mid-operation abandons the command. No later rf_w and no res_valid are produced for it.
  - A write already committed in an earlier cycle stands.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Any source field equal to 0 uses value 0 instead of rf_dout1/2.
  - For a command with rd=0, WRITE still occurs as a state but rf_w is held 0, so r0 is never written.
  - res_data still reports the computed value.
- Undefined: r0 is an ordinary register.

Test Plan:
- Reset: hold Rst 2 cycles with cmd_valid=1 -> cmd_ready=1, rf_w=rf_r=0, res_valid=0, res_data=0x00, res_carry=0, and no command accepted during reset.
- LOADI r3=0x5A, then READ rs1=3 -> rf_w high exactly 1 cycle with rf_addrw=3 and rf_datain=0x5A. READ gives res_data=0x5A with res_valid in C3 only.
- LOADI r1=0xF0 and LOADI r2=0x20, then ADD r4=r1+r2 -> res_data=0x10, res_carry=1, res_valid in C4. A following READ r4 gives 0x10.
- SUB r5=r2-r1 -> 0x30 with carry=1. SUB r6=r1-r2 -> 0xD0 with carry=0.
- r1=0x03, then two back-to-back ADD r1=r1+r1 with cmd_valid held throughout -> cmd_ready low during C1-C3. Results are 0x06 then 0x0C.
- Rst pulsed during EXEC of ADD r7=r1+r2 -> no rf_w for r7, no res_valid, and READ r7 returns the prior value.
- With REGFILE_R0_ZERO_EN: LOADI r0=0xFF produces no rf_w. ADD r8=r0+r2 (r2=0x20) gives 0x20.
